// File: rtl/dmem_stage_pkg.sv
// Shared types and helpers for the data-memory access stage.
// State encodings, byte-lane constants, load-lane extraction and byte-enable helpers.
// No clocked logic in this file.
package dmem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    // Little-endian lane pick plus optional sign/zero extension for byte loads.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic        byte_acc,
                                                 input logic        sign_ext);
        logic [7:0] b;
        case (lane)
            LANE0:   b = word[7:0];
            LANE1:   b = word[15:8];
            LANE2:   b = word[23:16];
            default: b = word[31:24];
        endcase
        if (!byte_acc)
            return word;
        else if (sign_ext)
            return {{24{b[7]}}, b};
        else
            return {24'd0, b};
    endfunction

    // One-hot byte enable for a single lane.
    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised on-chip data RAM with per-byte write enables.
// Latency: combinational read, write on rising edge.
// Backpressure: none; the controlling stage sequences all accesses.
module dmem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    // Byte-lane writes; lanes without an enable keep their contents.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (we_i[k])
                mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_stage.sv
// Data-memory stage: multi-cycle word/byte load/store with a pipeline stall (DMEM_ALIGN_CHK_EN adds misalignment trap).
// Latency: request in cycle 0, done pulse in cycle WAIT_CYCLES+1; store commits at the edge ending DONE.
// Backpressure: mem_busy_o holds the upstream pipeline (and thus these inputs) until the DONE cycle.
module dmem_stage
    import dmem_stage_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk_i,
    input  logic        clr_n_i,
    input  logic        req_valid_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic        byte_acc_i,
    input  logic        sign_ext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rd_o,
    output logic        mem_busy_o,
    output logic        done_o,
    output logic        align_err_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rd_q, rd_d;

    logic               acc;
    logic               misalign;
    logic [1:0]         lane;
    logic [ADDR_W-1:0]  word_idx;
    logic [3:0]         ram_we;
    logic [31:0]        ram_wdata;
    logic [31:0]        ram_rdata;
    logic               unused_addr_hi;

    assign acc      = req_valid_i & (mem_rd_i | mem_wr_i);
    assign lane     = addr_i[1:0];
    assign word_idx = addr_i[ADDR_W+1:2];
    // Address bits above the RAM size are ignored so addresses wrap.
    assign unused_addr_hi = ^addr_i[31:ADDR_W+2];

`ifdef DMEM_ALIGN_CHK_EN
    assign misalign    = ~byte_acc_i & (lane != LANE0);
    assign align_err_o = (state_q == ST_DONE) & misalign;
`else
    assign misalign    = 1'b0;
    assign align_err_o = 1'b0;
`endif

    // Next state: IDLE -> BUSY for WAIT_CYCLES cycles (or straight to DONE) -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Load result is captured on entry to DONE, so it reflects the pre-write word.
    always_comb begin
        rd_d = rd_q;
        if (state_d == ST_DONE && state_q != ST_DONE)
            rd_d = misalign ? 32'd0 : load_extract(ram_rdata, lane, byte_acc_i, sign_ext_i);
    end

    // State, counter and load-result registers with synchronous active-low clear.
    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    // Store commits only at the edge ending DONE and never while clear is asserted.
    always_comb begin
        ram_we = 4'b0000;
        if (state_q == ST_DONE && req_valid_i && mem_wr_i && clr_n_i && !misalign)
            ram_we = byte_acc_i ? lane_be(lane) : 4'b1111;
    end

    assign ram_wdata  = byte_acc_i ? {4{wdata_i[7:0]}} : wdata_i;
    assign mem_busy_o = clr_n_i & (((state_q == ST_IDLE) & acc) | (state_q == ST_BUSY));
    assign done_o     = (state_q == ST_DONE);
    assign rd_o       = rd_q;

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (word_idx),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_stage.sv
// Scoreboard bench for dmem_stage: directed cases plus randomized loads/stores against an array model.
// Expected responses are queued at issue time and popped by a monitor on each done pulse.
// Inputs are driven #1 after the rising edge and outputs sampled on the falling edge.
module tb_dmem_stage;

    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 2;
    localparam int NWORDS      = 1 << ADDR_W;
`ifdef DMEM_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr_n_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        mem_rd_i = 1'b0;
    logic        mem_wr_i = 1'b0;
    logic        byte_acc_i = 1'b0;
    logic        sign_ext_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rd_o;
    logic        mem_busy_o;
    logic        done_o;
    logic        align_err_o;

    typedef struct {
        bit          chk_rd;
        logic [31:0] rd;
        logic        aerr;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [NWORDS];
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dmem_stage #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES),
        .CNT_W       (4)
    ) dut (
        .clk_i       (clk),
        .clr_n_i     (clr_n_i),
        .req_valid_i (req_valid_i),
        .mem_rd_i    (mem_rd_i),
        .mem_wr_i    (mem_wr_i),
        .byte_acc_i  (byte_acc_i),
        .sign_ext_i  (sign_ext_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rd_o        (rd_o),
        .mem_busy_o  (mem_busy_o),
        .done_o      (done_o),
        .align_err_o (align_err_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: memory as a plain word array, lanes handled by shift/mask arithmetic.
    task automatic model_access(input bit r, input bit w, input bit b, input bit s,
                                input logic [31:0] a, input logic [31:0] d, output exp_t e);
        int unsigned idx;
        int unsigned sh;
        logic [31:0] old;
        logic [31:0] lane_val;
        idx = (a >> 2) % NWORDS;
        sh  = 8 * (a % 4);
        old = model[idx];
        e.chk_rd = r;
        e.aerr   = ALIGN && !b && (a % 4 != 0);
        if (e.aerr) begin
            e.rd = 32'd0;
        end else begin
            lane_val = (old >> sh) & 32'hFF;
            if (!b)
                e.rd = old;
            else if (s && lane_val >= 32'd128)
                e.rd = lane_val - 32'd256;
            else
                e.rd = lane_val;
            if (w)
                model[idx] = b ? ((old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh)) : d;
        end
    endtask

    task automatic drive(input bit r, input bit w, input bit b, input bit s,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid_i = 1'b1;
        mem_rd_i    = r;
        mem_wr_i    = w;
        byte_acc_i  = b;
        sign_ext_i  = s;
        addr_i      = a;
        wdata_i     = d;
    endtask

    task automatic idle_inputs();
        req_valid_i = 1'b0;
        mem_rd_i    = 1'b0;
        mem_wr_i    = 1'b0;
    endtask

    // Issue one access, hold it through DONE, check stall length and latency.
    task automatic access(input bit r, input bit w, input bit b, input bit s,
                          input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        int   busy;
        bit   got;
        model_access(r, w, b, s, a, d, e);
        sb_q.push_back(e);
        drive(r, w, b, s, a, d);
        n = 0; busy = 0; got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            if (mem_busy_o) busy++;
            if (done_o) got = 1'b1;
            else n++;
        end
        chk("latency", n, WAIT_CYCLES + 1);
        chk("busy_cycles", busy, WAIT_CYCLES + 1);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (clr_n_i && done_o) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no outstanding access");
            end else begin
                e = sb_q.pop_front();
                if (e.chk_rd) chk("rd", rd_o, e.rd);
                chk("align_err", align_err_o, e.aerr);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          n;
        bit          got;

        // Reset with a pending request: no stall, outputs cleared.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("reset_busy", mem_busy_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_rd", rd_o, 32'd0);
        chk("reset_done", done_o, 1'b0);
        chk("reset_busy2", mem_busy_o, 1'b0);
        chk("reset_aerr", align_err_o, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        clr_n_i = 1'b1;
        @(negedge clk);
        chk("idle_busy", mem_busy_o, 1'b0);
        chk("idle_done", done_o, 1'b0);
        chk("idle_rd", rd_o, 32'd0);
        @(posedge clk); #1;

        // Give the first 32 words known contents.
        for (int i = 0; i < 32; i++)
            access(1'b0, 1'b1, 1'b0, 1'b0, 32'(i * 4), $urandom);

        // Word store then load.
        access(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
        access(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);

        // Byte store into lane 3, word and byte reloads.
        access(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h11223344);
        access(1'b0, 1'b1, 1'b1, 1'b0, 32'h13, 32'hFFFFFF80);
        access(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        access(1'b1, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0);
        access(1'b1, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0);
        repeat (3) @(negedge clk);
        chk("rd_hold", rd_o, 32'h00000080);
        @(posedge clk); #1;

        // Clear while BUSY: store abandoned, no done pulse.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'hAAAA5555);
        @(negedge clk);
        chk("abort_busy_pre", mem_busy_o, 1'b1);
        @(posedge clk); #1;
        clr_n_i = 1'b0;
        @(negedge clk);
        chk("abort_busy_clr", mem_busy_o, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("abort_done", done_o, 1'b0);
        @(posedge clk); #1;
        clr_n_i = 1'b1;
        access(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);

        // Clear during DONE: the store must not commit.
        begin
            exp_t e;
            e.chk_rd = 1'b0; e.rd = 32'd0; e.aerr = 1'b0;
            sb_q.push_back(e);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h24, 32'hC0FFEE11);
        n = 0; got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            if (done_o) got = 1'b1;
            else n++;
        end
        chk("rstdone_latency", n, WAIT_CYCLES + 1);
        #1 clr_n_i = 1'b0;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        clr_n_i = 1'b1;
        access(1'b1, 1'b0, 1'b0, 1'b0, 32'h24, 32'h0);

        // Address wrap through bits above the RAM size.
        access(1'b0, 1'b1, 1'b0, 1'b0, 32'h10 + (32'd4 << ADDR_W), 32'h12345678);
        access(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);

        // Misaligned word load, then confirm the word is intact.
        access(1'b1, 1'b0, 1'b0, 1'b0, 32'h22, 32'h0);
        access(1'b0, 1'b1, 1'b0, 1'b0, 32'h26, 32'h55AA55AA);
        access(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
        access(1'b1, 1'b0, 1'b0, 1'b0, 32'h24, 32'h0);

        // Load-and-store together behaves as a store returning the old data.
        access(1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0BADF00D);
        access(1'b1, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0);

        // Randomized mix over the known region with random high address bits.
        for (int i = 0; i < 200; i++) begin
            int unsigned op;
            bit r, w;
            op = $urandom_range(0, 3);
            r  = (op == 0) || (op == 2);
            w  = (op != 0);
            a  = (32'($urandom_range(0, 7)) << (ADDR_W + 2))
               | (32'($urandom_range(0, 31)) << 2)
               | 32'($urandom_range(0, 3));
            access(r, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
